// File: rtl/img_pkg.sv
// Shared pixel-pipeline definitions: default geometry, pixel type, row-count helpers.
package img_pkg;

  localparam int unsigned IMG_WIDTH_DATA = 24;
  localparam int unsigned IMG_WIDTH_LINE = 800;
  localparam int unsigned ADDR_W         = 11;

  typedef logic [IMG_WIDTH_DATA-1:0] pix_t;

  // Number of buffered lines since frame start, saturating at two.
  typedef logic [1:0] row_cnt_t;

  localparam row_cnt_t ROW_NONE = 2'd0;
  localparam row_cnt_t ROW_FULL = 2'd2;

  // Saturating increment of the buffered-line count.
  function automatic row_cnt_t row_sat_inc(input row_cnt_t r);
    return (r == ROW_FULL) ? ROW_FULL : row_cnt_t'(r + 2'd1);
  endfunction

endpackage

// File: rtl/img_line_ram.sv
// Single line buffer: one write port, one registered read port, read-before-write.
module img_line_ram #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 800,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;

  assign widx = waddr[IDX_W-1:0];
  assign ridx = raddr[IDX_W-1:0];

  // Write port; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (we && (waddr < ADDR_LIM)) begin
      mem[widx] <= wdata;
    end
  end

  // Registered read; returns the pre-write content on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (raddr < ADDR_LIM) ? mem[ridx] : '0;
    end
  end

endmodule

// File: rtl/img_line_window.sv
// Vertical 3-tap window: current pixel plus the two previous lines at the same column.
module img_line_window #(
  parameter int unsigned IMG_WIDTH_DATA = img_pkg::IMG_WIDTH_DATA,
  parameter int unsigned IMG_WIDTH_LINE = img_pkg::IMG_WIDTH_LINE,
  parameter int unsigned ADDR_W         = img_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_valid,
  input  logic                      pix_sof,
  input  logic                      pix_eol,
  input  logic [IMG_WIDTH_DATA-1:0] pix_data,
  output logic                      win_valid,
  output logic [IMG_WIDTH_DATA-1:0] win_tap0,
  output logic [IMG_WIDTH_DATA-1:0] win_tap1,
  output logic [IMG_WIDTH_DATA-1:0] win_tap2,
  output logic [ADDR_W-1:0]         win_col,
  output logic                      win_row_ok,
  output logic                      ovf_err
);
  import img_pkg::*;

  localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(IMG_WIDTH_LINE);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_WIDTH_LINE - 1);

  // Line position state; col may reach COL_MAX to flag overflowing pixels.
  logic [ADDR_W-1:0] col_q;
  logic [ADDR_W-1:0] col_d;
  row_cnt_t          row_q;
  row_cnt_t          row_d;
  logic              sel_q;
  logic              sel_d;

  // Position of the pixel being accepted this cycle (sof overrides stored state).
  logic [ADDR_W-1:0] cur_col;
  row_cnt_t          cur_row;
  logic              cur_sel;
  logic              pix_ovf;
  logic [ADDR_W-1:0] acc_col;
  logic              we0;
  logic              we1;

  // State of the pixel whose RAM read is in flight.
  row_cnt_t          row_dly;
  logic              sel_dly;
  logic              ovf_dly;

  logic [IMG_WIDTH_DATA-1:0] rdata0;
  logic [IMG_WIDTH_DATA-1:0] rdata1;
  logic [IMG_WIDTH_DATA-1:0] ram_n1;
  logic [IMG_WIDTH_DATA-1:0] ram_n2;

  // Next-state for column/row/select and write steering to the RAM holding row n-2.
  always_comb begin
    cur_col = pix_sof ? '0 : col_q;
    cur_row = pix_sof ? ROW_NONE : row_q;
    cur_sel = pix_sof ? 1'b0 : sel_q;
    pix_ovf = (cur_col >= COL_MAX);
    acc_col = pix_ovf ? COL_LAST : cur_col;
    col_d   = col_q;
    row_d   = row_q;
    sel_d   = sel_q;
    we0     = 1'b0;
    we1     = 1'b0;
    if (pix_valid) begin
      we0 = ~pix_ovf & cur_sel;
      we1 = ~pix_ovf & ~cur_sel;
      if (pix_eol) begin
        col_d = '0;
        row_d = row_sat_inc(cur_row);
        sel_d = ~cur_sel;
      end else begin
        col_d = pix_ovf ? cur_col : cur_col + ADDR_W'(1);
        row_d = cur_row;
        sel_d = cur_sel;
      end
    end
  end

  // Line position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= ROW_NONE;
      sel_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      sel_q <= sel_d;
    end
  end

  // One-cycle alignment registers matching the RAM read latency; hold across gaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_valid <= 1'b0;
      win_tap0  <= '0;
      win_col   <= '0;
      row_dly   <= ROW_NONE;
      sel_dly   <= 1'b0;
      ovf_dly   <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      win_valid <= pix_valid;
      if (pix_valid) begin
        win_tap0 <= pix_data;
        win_col  <= acc_col;
        row_dly  <= cur_row;
        sel_dly  <= cur_sel;
        ovf_dly  <= pix_ovf;
        if (pix_ovf) begin
          ovf_err <= 1'b1;
        end
      end
    end
  end

  // Route RAM outputs to rows n-1/n-2 and blank rows not yet filled in this frame.
  always_comb begin
    ram_n1     = sel_dly ? rdata1 : rdata0;
    ram_n2     = sel_dly ? rdata0 : rdata1;
    win_tap1   = ((row_dly != ROW_NONE) && !ovf_dly) ? ram_n1 : '0;
    win_tap2   = ((row_dly == ROW_FULL) && !ovf_dly) ? ram_n2 : '0;
    win_row_ok = (row_dly == ROW_FULL);
  end

  img_line_ram #(
    .DATA_W (IMG_WIDTH_DATA),
    .DEPTH  (IMG_WIDTH_LINE),
    .ADDR_W (ADDR_W)
  ) u_ram0 (
    .clk   (clk),
    .reset (1'b0),
    .we    (we0),
    .waddr (acc_col),
    .wdata (pix_data),
    .re    (pix_valid),
    .raddr (acc_col),
    .rdata (rdata0)
  );

  img_line_ram #(
    .DATA_W (IMG_WIDTH_DATA),
    .DEPTH  (IMG_WIDTH_LINE),
    .ADDR_W (ADDR_W)
  ) u_ram1 (
    .clk   (clk),
    .reset (1'b0),
    .we    (we1),
    .waddr (acc_col),
    .wdata (pix_data),
    .re    (pix_valid),
    .raddr (acc_col),
    .rdata (rdata1)
  );

endmodule

// File: tb/tb_img_line_window.sv
// Bench for img_line_window: line-history model checked every cycle plus literal pins.
module tb_img_line_window;

  localparam int unsigned W  = 24;
  localparam int unsigned L  = 800;
  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_eol;
  logic [W-1:0]  pix_data;
  logic          win_valid;
  logic [W-1:0]  win_tap0;
  logic [W-1:0]  win_tap1;
  logic [W-1:0]  win_tap2;
  logic [AW-1:0] win_col;
  logic          win_row_ok;
  logic          ovf_err;

  img_line_window dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_data   (pix_data),
    .win_valid  (win_valid),
    .win_tap0   (win_tap0),
    .win_tap1   (win_tap1),
    .win_tap2   (win_tap2),
    .win_col    (win_col),
    .win_row_ok (win_row_ok),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: row index since frame start, column in line, and stored line history.
  int            m_row;
  int            m_col;
  logic [W-1:0]  cur_line [L];
  logic [W-1:0]  prev1 [L];
  logic [W-1:0]  prev2 [L];
  logic          e_valid;
  logic          e_row_ok;
  logic          e_ovf;
  logic [W-1:0]  e_t0;
  logic [W-1:0]  e_t1;
  logic [W-1:0]  e_t2;
  logic [AW-1:0] e_col;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the pixel sampled at this edge.
  always @(posedge clk) begin
    if (reset) begin
      m_row = 0; m_col = 0;
      e_valid = 0; e_row_ok = 0; e_ovf = 0;
      e_t0 = '0; e_t1 = '0; e_t2 = '0; e_col = '0;
    end else begin
      e_valid = pix_valid;
      if (pix_valid) begin
        if (pix_sof) begin
          m_row = 0; m_col = 0;
        end
        e_t0 = pix_data;
        e_row_ok = (m_row >= 2);
        if (m_col >= int'(L)) begin
          e_ovf = 1'b1;
          e_col = AW'(L - 1);
          e_t1 = '0;
          e_t2 = '0;
        end else begin
          e_col = AW'(m_col);
          e_t1 = (m_row >= 1) ? prev1[m_col] : '0;
          e_t2 = (m_row >= 2) ? prev2[m_col] : '0;
          cur_line[m_col] = pix_data;
        end
        if (pix_eol) begin
          prev2 = prev1;
          prev1 = cur_line;
          m_row++;
          m_col = 0;
        end else begin
          m_col++;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("win_valid",  32'(win_valid),  32'(e_valid));
      chk("win_tap0",   32'(win_tap0),   32'(e_t0));
      chk("win_tap1",   32'(win_tap1),   32'(e_t1));
      chk("win_tap2",   32'(win_tap2),   32'(e_t2));
      chk("win_col",    32'(win_col),    32'(e_col));
      chk("win_row_ok", 32'(win_row_ok), 32'(e_row_ok));
      chk("ovf_err",    32'(ovf_err),    32'(e_ovf));
    end
  end

  task automatic px(input logic s, input logic e, input logic [W-1:0] d);
    @(negedge clk);
    pix_valid = 1'b1; pix_sof = s; pix_eol = e; pix_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0; pix_data = 24'hDEAD00;
    end
  endtask

  task automatic line(input int base, input int row, input int n, input bit sof);
    for (int c = 0; c < n; c++) begin
      px(sof && (c == 0), c == n - 1, W'(base + row * 16 + c));
    end
  endtask

  // Pins showing the col-2 output of the line just driven (visible while col 3 is driven).
  task automatic pin3(input string tag, input logic [W-1:0] t0, input logic [W-1:0] t1,
                      input logic [W-1:0] t2, input logic ok);
    chk({tag, "_tap0"}, 32'(win_tap0), 32'(t0));
    chk({tag, "_tap1"}, 32'(win_tap1), 32'(t1));
    chk({tag, "_tap2"}, 32'(win_tap2), 32'(t2));
    chk({tag, "_rowok"}, 32'(win_row_ok), 32'(ok));
  endtask

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0; pix_data = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_valid", 32'(win_valid), 32'd0);
    chk("rst_tap0",  32'(win_tap0),  32'd0);
    chk("rst_ovf",   32'(ovf_err),   32'd0);
    reset = 1'b0;
    idle(2);

    // Frame A: 4-px lines, value row*16+col.
    line(0, 0, 4, 1'b1);
    pin3("a_r0", 24'h02, 24'h00, 24'h00, 1'b0);
    line(0, 1, 4, 1'b0);
    pin3("a_r1", 24'h12, 24'h02, 24'h00, 1'b0);
    px(1'b0, 1'b0, 24'h20);
    px(1'b0, 1'b0, 24'h21);
    idle(1);
    chk("gap_valid1", 32'(win_valid), 32'd1);
    pin3("a_r2c1", 24'h21, 24'h11, 24'h01, 1'b1);
    chk("a_r2c1_col", 32'(win_col), 32'd1);
    idle(1);
    chk("gap_valid0", 32'(win_valid), 32'd0);
    pin3("gap_hold", 24'h21, 24'h11, 24'h01, 1'b1);
    chk("gap_col", 32'(win_col), 32'd1);
    px(1'b0, 1'b0, 24'h22);
    px(1'b0, 1'b1, 24'h23);
    line(0, 3, 4, 1'b0);
    line(0, 4, 4, 1'b0);
    pin3("a_r4", 24'h42, 24'h32, 24'h22, 1'b1);

    // Frame B starts where row 5 of frame A would be.
    line(32'h100, 0, 4, 1'b1);
    pin3("b_r0", 24'h102, 24'h0, 24'h0, 1'b0);
    line(32'h100, 1, 4, 1'b0);
    pin3("b_r1", 24'h112, 24'h102, 24'h0, 1'b0);
    line(32'h100, 2, 4, 1'b0);
    pin3("b_r2", 24'h122, 24'h112, 24'h102, 1'b1);
    idle(3);

    // Frame C: single-pixel lines (sof and eol together on the first).
    px(1'b1, 1'b1, 24'h300);
    px(1'b0, 1'b1, 24'h301);
    px(1'b0, 1'b1, 24'h302);
    px(1'b0, 1'b1, 24'h303);
    pin3("c_r2", 24'h302, 24'h301, 24'h300, 1'b1);
    chk("c_col", 32'(win_col), 32'd0);
    idle(2);

    // Frame D: overflowing line then a full-length line.
    for (int c = 0; c < 802; c++) begin
      px(c == 0, c == 801, (c == 800) ? 24'hAAAAAA : (c == 801) ? 24'hBBBBBB : W'(32'h400000 + c));
      if (c == 800) begin
        chk("pre_ovf", 32'(ovf_err), 32'd0);
        chk("pre_ovf_col", 32'(win_col), 32'd799);
      end
      if (c == 801) begin
        chk("ovf_set", 32'(ovf_err), 32'd1);
        chk("ovf_col", 32'(win_col), 32'd799);
        chk("ovf_tap0", 32'(win_tap0), 32'hAAAAAA);
        chk("ovf_tap1", 32'(win_tap1), 32'd0);
      end
    end
    for (int c = 0; c < 800; c++) begin
      px(1'b0, c == 799, W'(32'h500000 + c));
      if (c == 1) chk("d_r1c0_tap1", 32'(win_tap1), 32'h400000);
    end
    idle(1);
    chk("d_r1c799_tap1", 32'(win_tap1), 32'h40031F);
    chk("d_r1c799_col",  32'(win_col),  32'd799);
    chk("ovf_sticky",    32'(ovf_err),  32'd1);
    idle(2);

    // Frame E: reset in the middle of row 2, then lines without sof.
    line(32'h600, 0, 4, 1'b1);
    line(32'h600, 1, 4, 1'b0);
    px(1'b0, 1'b0, 24'h620);
    px(1'b0, 1'b0, 24'h621);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    chk("mrst_valid", 32'(win_valid),  32'd0);
    chk("mrst_tap0",  32'(win_tap0),   32'd0);
    chk("mrst_tap1",  32'(win_tap1),   32'd0);
    chk("mrst_tap2",  32'(win_tap2),   32'd0);
    chk("mrst_col",   32'(win_col),    32'd0);
    chk("mrst_rowok", 32'(win_row_ok), 32'd0);
    chk("mrst_ovf",   32'(ovf_err),    32'd0);
    line(32'h700, 0, 4, 1'b0);
    pin3("e_r0", 24'h702, 24'h0, 24'h0, 1'b0);
    line(32'h700, 1, 4, 1'b0);
    pin3("e_r1", 24'h712, 24'h702, 24'h0, 1'b0);
    line(32'h700, 2, 4, 1'b0);
    pin3("e_r2", 24'h722, 24'h712, 24'h702, 1'b1);
    idle(3);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
